// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: word width, instruction field widths and the word type.
package lc3_pkg;

  localparam int WORD_W = 16;

  localparam int IMM5_W       = 5;
  localparam int OFFSET6_W    = 6;
  localparam int PCOFFSET9_W  = 9;
  localparam int TRAPVECT8_W  = 8;
  localparam int PCOFFSET11_W = 11;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/lc3_sext_core.sv
// Combinational extender: widens in[N-1:0] to a full LC-3 word.
// With LC3_SEXT_ZEXT_EN defined, a zext input selects zero- instead of sign-extension.
module lc3_sext_core
  import lc3_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [15:0] in,
`ifdef LC3_SEXT_ZEXT_EN
  input  logic        zext,
`endif
  output logic [15:0] ext
);

  // Out-of-range widths must stop elaboration rather than silently truncate.
  generate
    if (N < 1 || N > 16) begin : g_bad_width
      $error("lc3_sext_core: N must be in 1..16");
    end
  endgenerate

  // Upper source bits are deliberately ignored.
  logic unused_in;
  assign unused_in = ^in;

  logic fill;
`ifdef LC3_SEXT_ZEXT_EN
  assign fill = zext ? 1'b0 : in[N-1];
`else
  assign fill = in[N-1];
`endif

  generate
    if (N == 16) begin : g_pass
      logic unused_fill;
      assign unused_fill = fill;
      assign ext = in;
    end else begin : g_extend
      assign ext = {{(16-N){fill}}, in[N-1:0]};
    end
  endgenerate

endmodule

// File: rtl/lc3_sext.sv
// Registered sign-extension unit: one-cycle latency, one field per cycle.
// Optional zero-extension select is enabled by defining LC3_SEXT_ZEXT_EN.
module lc3_sext
  import lc3_pkg::*;
#(
  parameter int N      = 8,
  parameter int WORD_W = lc3_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in,
`ifdef LC3_SEXT_ZEXT_EN
  input  logic              zext,
`endif
  output logic [WORD_W-1:0] out,
  output logic              out_valid
);

  generate
    if (WORD_W != 16) begin : g_bad_word
      $error("lc3_sext: WORD_W is fixed at 16");
    end
  endgenerate

  word_t ext;

  lc3_sext_core #(
    .N(N)
  ) u_core (
    .in  (in),
`ifdef LC3_SEXT_ZEXT_EN
    .zext(zext),
`endif
    .ext (ext)
  );

  // out holds on idle cycles; out_valid marks only the edge that loaded it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= ext;
      end
    end
  end

endmodule

// File: tb/tb_lc3_sext.sv
// Scoreboard bench for lc3_sext: four instances (N = 8, 4, 16, 1) share clock and reset.
module tb_lc3_sext;

  localparam int NS [4] = '{8, 4, 16, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din  [4];
  logic        vin  [4];
  logic [15:0] dout [4];
  logic        vout [4];
`ifdef LC3_SEXT_ZEXT_EN
  logic        zext;
`endif

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      lc3_sext #(.N(NS[gi])) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vin[gi]),
        .in       (din[gi]),
`ifdef LC3_SEXT_ZEXT_EN
        .zext     (zext),
`endif
        .out      (dout[gi]),
        .out_valid(vout[gi])
      );
    end
  endgenerate

  typedef struct {
    int          idx;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every valid output pops the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vout[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_valid inst=%0d actual=%h required=none", i, dout[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("[TB] inst=%0d N=%0d %s out=%h expected=%h", i, NS[i], e.name, dout[i], e.val);
          check({e.name, "_inst"}, 16'(i), 16'(e.idx));
          check(e.name, dout[i], e.val);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] d, input logic [15:0] e, input string name);
    exp_t x;
    x.idx = i; x.val = e; x.name = name;
    vin[i] = 1'b1;
    din[i] = d;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    vin[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
`ifdef LC3_SEXT_ZEXT_EN
    zext = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b0;
      din[i] = 16'h0000;
    end
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_out%0d", i), dout[i], 16'h0000);
      check($sformatf("reset_valid%0d", i), {15'b0, vout[i]}, 16'h0000);
    end
    #9 rst = 1'b0;
    @(posedge clk); #1;

    issue(0, 16'h0080, 16'hFF80, "n8_neg");
    issue(0, 16'h007F, 16'h007F, "n8_pos");
    issue(1, 16'h0008, 16'hFFF8, "n4_neg");
    issue(1, 16'h0007, 16'h0007, "n4_pos");
    issue(1, 16'hAB05, 16'h0005, "n4_garbage");
    issue(2, 16'h8001, 16'h8001, "n16_pass");
    issue(3, 16'h0001, 16'hFFFF, "n1_one");
    issue(3, 16'hFFFE, 16'h0000, "n1_zero");

    // Hold: idle cycle must keep the last word and drop valid.
    issue(0, 16'h0080, 16'hFF80, "hold_load");
    din[0] = 16'h0001;
    @(posedge clk); #1;
    check("hold_out", dout[0], 16'hFF80);
    check("hold_valid", {15'b0, vout[0]}, 16'h0000);

    issue(1, 16'h0009, 16'hFFF9, "b2b_0");
    issue(1, 16'h0003, 16'h0003, "b2b_1");
    issue(1, 16'h000F, 16'hFFFF, "b2b_2");
    repeat (2) @(posedge clk);
    #1;

`ifdef LC3_SEXT_ZEXT_EN
    zext = 1'b1;
    issue(0, 16'h00FF, 16'h00FF, "zext_on");
    zext = 1'b0;
    issue(0, 16'h00FF, 16'hFFFF, "zext_off");
`else
    issue(0, 16'h00FF, 16'hFFFF, "sext_ff");
`endif

    // Asynchronous reset between edges, then a field presented during reset is dropped.
    issue(1, 16'h0008, 16'hFFF8, "pre_reset");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_out", dout[1], 16'h0000);
    check("rst_async_valid", {15'b0, vout[1]}, 16'h0000);
    vin[1] = 1'b1;
    din[1] = 16'h0007;
    @(posedge clk); #1;
    vin[1] = 1'b0;
    check("rst_discard_out", dout[1], 16'h0000);
    check("rst_discard_valid", {15'b0, vout[1]}, 16'h0000);
    #2 rst = 1'b0;
    issue(1, 16'h000A, 16'hFFFA, "post_reset");
    check("post_reset_valid", {15'b0, vout[1]}, 16'h0001);
    check("post_reset_out", dout[1], 16'hFFFA);

    repeat (3) @(posedge clk);
    #1;
    check("drain", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
